// File: rtl/vip_pkt_pkg.sv
// Shared constants, types and helpers for the VIP control-packet inserter.
package vip_pkt_pkg;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
  localparam int         CTRL_NIBBLES   = 9;

  // Number of body beats needed to carry the nine geometry nibbles.
  function automatic int ctrl_beats(input int symbols);
    return (CTRL_NIBBLES + symbols - 1) / symbols;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_BODY   = 3'd2,
    ST_PASS   = 3'd3,
    ST_DROP   = 3'd4
  } state_e;

endpackage

// File: rtl/vip_st_output_reg.sv
// One-deep valid/ready register stage carrying data, sop and eop.
module vip_st_output_reg #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;

  // The register is free when empty or when its beat leaves this cycle.
  assign in_ready = ~valid_q | out_ready;

  // Load a new beat when free; otherwise hold everything stable.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
        sop_d  = in_sop;
        eop_d  = in_eop;
      end
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;

endmodule

// File: rtl/vip_ctrl_packet_inserter.sv
// Inserts a VIP control packet ahead of the next video packet whenever new
// frame geometry is requested; optionally drops stale upstream control packets.
module vip_ctrl_packet_inserter
  import vip_pkt_pkg::*;
#(
  parameter int BITS_PER_SYMBOL    = 8,
  parameter int SYMBOLS_PER_BEAT   = 3,
  parameter int DROP_UPSTREAM_CTRL = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic                                        din_ready,
  input  logic                                        din_valid,
  input  logic                                        din_sop,
  input  logic                                        din_eop,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  input  logic                                        do_control_packet,
  input  logic [15:0]                                 width,
  input  logic [15:0]                                 height,
  input  logic [3:0]                                  interlaced,
  output logic                                        ctrl_sent
);

  localparam int DATA_W     = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int CTRL_BEATS = ctrl_beats(SYMBOLS_PER_BEAT);
  localparam int CNT_W      = $clog2(CTRL_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CTRL_BEATS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [15:0]       pend_w_q, pend_w_d, pend_h_q, pend_h_d;
  logic [3:0]        pend_i_q, pend_i_d;
  logic [15:0]       snap_w_q, snap_w_d, snap_h_q, snap_h_d;
  logic [3:0]        snap_i_q, snap_i_d;
  logic              ctrl_last_q, ctrl_last_d;

  logic              out_free;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_sop;
  logic              ld_eop;
  logic              ld_ctrl_last;

  logic [CTRL_NIBBLES*4-1:0]          nib_vec;
  logic [CTRL_BEATS-1:0][DATA_W-1:0]  body_beat;
  logic [DATA_W-1:0]                  header_beat;

  // Nibble k of the control body lives at nib_vec[4k +: 4], width MSN first.
  assign nib_vec = {snap_i_q,
                    snap_h_q[3:0], snap_h_q[7:4], snap_h_q[11:8], snap_h_q[15:12],
                    snap_w_q[3:0], snap_w_q[7:4], snap_w_q[11:8], snap_w_q[15:12]};

  assign header_beat = DATA_W'(PKT_TYPE_CTRL);

  for (genvar b = 0; b < CTRL_BEATS; b++) begin : g_beat
    for (genvar s = 0; s < SYMBOLS_PER_BEAT; s++) begin : g_sym
      localparam int IDX = b * SYMBOLS_PER_BEAT + s;
      if (IDX < CTRL_NIBBLES) begin : g_nib
        assign body_beat[b][s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] =
          BITS_PER_SYMBOL'(nib_vec[IDX*4 +: 4]);
      end else begin : g_pad
        assign body_beat[b][s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] = '0;
      end
    end
  end

  // Next-state, request capture, sink handshake and output-register load.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    pend_w_d     = pend_w_q;
    pend_h_d     = pend_h_q;
    pend_i_d     = pend_i_q;
    snap_w_d     = snap_w_q;
    snap_h_d     = snap_h_q;
    snap_i_d     = snap_i_q;
    ld_valid     = 1'b0;
    ld_data      = din_data;
    ld_sop       = din_sop;
    ld_eop       = din_eop;
    ld_ctrl_last = 1'b0;
    din_ready    = 1'b0;

    if (do_control_packet) begin
      pending_d = 1'b1;
      pend_w_d  = width;
      pend_h_d  = height;
      pend_i_d  = interlaced;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q || do_control_packet) begin
          // A same-cycle request is taken directly so the header is not delayed.
          state_d   = ST_HEADER;
          pending_d = 1'b0;
          snap_w_d  = do_control_packet ? width      : pend_w_q;
          snap_h_d  = do_control_packet ? height     : pend_h_q;
          snap_i_d  = do_control_packet ? interlaced : pend_i_q;
        end else begin
          // Stray non-sop beats are discarded; a sop waits for the next state.
          din_ready = din_valid & ~din_sop;
          if (din_valid && din_sop) begin
            if ((DROP_UPSTREAM_CTRL != 0) && (din_data[3:0] == PKT_TYPE_CTRL)) begin
              state_d = ST_DROP;
            end else begin
              state_d = ST_PASS;
            end
          end
        end
      end
      ST_HEADER: begin
        if (out_free) begin
          ld_valid = 1'b1;
          ld_data  = header_beat;
          ld_sop   = 1'b1;
          ld_eop   = 1'b0;
          cnt_d    = '0;
          state_d  = ST_BODY;
        end
      end
      ST_BODY: begin
        if (out_free) begin
          ld_valid     = 1'b1;
          ld_data      = body_beat[cnt_q];
          ld_sop       = 1'b0;
          ld_eop       = (cnt_q == LAST_BEAT);
          ld_ctrl_last = (cnt_q == LAST_BEAT);
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PASS: begin
        din_ready = out_free;
        if (din_valid && out_free) begin
          ld_valid = 1'b1;
          if (din_eop) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        din_ready = 1'b1;
        if (din_valid && din_eop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ctrl_last_d = ld_valid ? ld_ctrl_last : ctrl_last_q;
  end

  // Control state, request register and geometry snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      pend_w_q    <= '0;
      pend_h_q    <= '0;
      pend_i_q    <= '0;
      snap_w_q    <= '0;
      snap_h_q    <= '0;
      snap_i_q    <= '0;
      ctrl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      pend_w_q    <= pend_w_d;
      pend_h_q    <= pend_h_d;
      pend_i_q    <= pend_i_d;
      snap_w_q    <= snap_w_d;
      snap_h_q    <= snap_h_d;
      snap_i_q    <= snap_i_d;
      ctrl_last_q <= ctrl_last_d;
    end
  end

  vip_st_output_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ld_valid),
    .in_ready (out_free),
    .in_data  (ld_data),
    .in_sop   (ld_sop),
    .in_eop   (ld_eop),
    .out_ready(dout_ready),
    .out_valid(dout_valid),
    .out_data (dout_data),
    .out_sop  (dout_sop),
    .out_eop  (dout_eop)
  );

  assign ctrl_sent = dout_valid & dout_ready & ctrl_last_q;

endmodule

// File: tb/tb_vip_ctrl_packet_inserter.sv
// Scoreboard bench: DUT A is S=3/BPS=8 with upstream-ctrl drop, DUT B is
// S=1/BPS=8 forwarding upstream control packets.
module tb_vip_ctrl_packet_inserter;

  typedef struct packed {
    logic [23:0] data;
    logic        sop;
    logic        eop;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A signals
  logic        rst_a, a_din_ready, a_din_valid, a_din_sop, a_din_eop;
  logic [23:0] a_din_data, a_dout_data;
  logic        a_dout_ready = 1'b1;
  logic        a_dout_valid, a_dout_sop, a_dout_eop, a_req, a_ctrl_sent;
  logic [15:0] a_w, a_h;
  logic [3:0]  a_i;
  // DUT B signals
  logic        rst_b, b_din_ready, b_din_valid, b_din_sop, b_din_eop;
  logic [7:0]  b_din_data, b_dout_data;
  wire         b_dout_ready = 1'b1;
  logic        b_dout_valid, b_dout_sop, b_dout_eop, b_req, b_ctrl_sent;
  logic [15:0] b_w, b_h;
  logic [3:0]  b_i;

  beat_t q_a[$];
  beat_t q_b[$];
  int    total = 0;
  int    bad   = 0;
  logic  rnd_en = 1'b0;
  logic  b_ign  = 1'b0;
  logic  a_stall_prev = 1'b0;
  logic [25:0] a_hold = '0;

  logic [7:0] bv1 [10] = '{8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] bv2 [10] = '{8'h0F, 8'h00, 8'h00, 8'h0A, 8'h0B, 8'h00, 8'h00, 8'h0C, 8'h0D, 8'h01};

  vip_ctrl_packet_inserter #(
    .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .DROP_UPSTREAM_CTRL(1)
  ) dut_a (
    .clk(clk), .rst(rst_a),
    .din_ready(a_din_ready), .din_valid(a_din_valid), .din_sop(a_din_sop),
    .din_eop(a_din_eop), .din_data(a_din_data),
    .dout_ready(a_dout_ready), .dout_valid(a_dout_valid), .dout_sop(a_dout_sop),
    .dout_eop(a_dout_eop), .dout_data(a_dout_data),
    .do_control_packet(a_req), .width(a_w), .height(a_h), .interlaced(a_i),
    .ctrl_sent(a_ctrl_sent)
  );

  vip_ctrl_packet_inserter #(
    .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1), .DROP_UPSTREAM_CTRL(0)
  ) dut_b (
    .clk(clk), .rst(rst_b),
    .din_ready(b_din_ready), .din_valid(b_din_valid), .din_sop(b_din_sop),
    .din_eop(b_din_eop), .din_data(b_din_data),
    .dout_ready(b_dout_ready), .dout_valid(b_dout_valid), .dout_sop(b_dout_sop),
    .dout_eop(b_dout_eop), .dout_data(b_dout_data),
    .do_control_packet(b_req), .width(b_w), .height(b_h), .interlaced(b_i),
    .ctrl_sent(b_ctrl_sent)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Pseudo-random backpressure on DUT A when enabled.
  always @(posedge clk) begin
    #1 a_dout_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor A: compare each accepted beat and check stall stability.
  always @(negedge clk) begin
    beat_t e;
    if (rst_a) begin
      a_stall_prev = 1'b0;
    end else begin
      if (a_dout_valid && a_stall_prev)
        chk("a_stall_hold", {a_dout_data, a_dout_sop, a_dout_eop}, a_hold);
      if (a_dout_valid && !a_dout_ready)
        chk("a_ctrl_sent_stall", a_ctrl_sent, 0);
      if (a_dout_valid && a_dout_ready) begin
        if (q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected actual=%h required=none", a_dout_data);
        end else begin
          e = q_a.pop_front();
          chk("a_beat", {a_dout_data, a_dout_sop, a_dout_eop}, {e.data, e.sop, e.eop});
          chk("a_ctrl_sent", a_ctrl_sent, e.last);
        end
      end
      a_stall_prev = a_dout_valid && !a_dout_ready;
      a_hold       = {a_dout_data, a_dout_sop, a_dout_eop};
    end
  end

  // Monitor B: compare each accepted beat.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_b && !b_ign && b_dout_valid && b_dout_ready) begin
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected actual=%h required=none", b_dout_data);
      end else begin
        e = q_b.pop_front();
        chk("b_beat", {b_dout_data, b_dout_sop, b_dout_eop}, {e.data[7:0], e.sop, e.eop});
        chk("b_ctrl_sent", b_ctrl_sent, e.last);
      end
    end
  end

  task automatic push_a(input logic [23:0] d, input logic s, input logic e, input logic l);
    q_a.push_back('{data: d, sop: s, eop: e, last: l});
  endtask

  // Expected S=3 control packet built from the geometry nibbles.
  task automatic push_a_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] i);
    logic [3:0] n [9];
    n = '{w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], i};
    push_a(24'h00000F, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++)
      push_a({4'h0, n[3*b+2], 4'h0, n[3*b+1], 4'h0, n[3*b]}, 1'b0, b == 2, b == 2);
  endtask

  task automatic push_b_ctrl(input logic [7:0] v [10]);
    for (int k = 0; k < 10; k++)
      q_b.push_back('{data: {16'h0, v[k]}, sop: k == 0, eop: k == 9, last: k == 9});
  endtask

  task automatic a_req_pulse(input logic [15:0] w, input logic [15:0] h, input logic [3:0] i);
    a_req = 1'b1; a_w = w; a_h = h; a_i = i;
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic b_req_pulse(input logic [15:0] w, input logic [15:0] h, input logic [3:0] i);
    b_req = 1'b1; b_w = w; b_h = h; b_i = i;
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  task automatic a_send(input logic [23:0] d, input logic s, input logic e);
    logic acc = 1'b0;
    a_din_valid = 1'b1; a_din_data = d; a_din_sop = s; a_din_eop = e;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (a_din_ready) begin acc = 1'b1; break; end
    end
    @(posedge clk); #1;
    a_din_valid = 1'b0;
    chk("a_send_accepted", acc, 1);
  endtask

  task automatic b_send(input logic [7:0] d, input logic s, input logic e);
    logic acc = 1'b0;
    b_din_valid = 1'b1; b_din_data = d; b_din_sop = s; b_din_eop = e;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (b_din_ready) begin acc = 1'b1; break; end
    end
    @(posedge clk); #1;
    b_din_valid = 1'b0;
    chk("b_send_accepted", acc, 1);
  endtask

  // Video packet: beat k carries base+k; sop beat has type nibble 0.
  task automatic a_pkt(input int n, input logic [23:0] base);
    for (int k = 0; k < n; k++) push_a(base + 24'(k), k == 0, k == n - 1, 1'b0);
    for (int k = 0; k < n; k++) a_send(base + 24'(k), k == 0, k == n - 1);
  endtask

  task automatic a_drain();
    for (int t = 0; t < 3000 && q_a.size() != 0; t++) @(negedge clk);
    chk("a_drain", q_a.size(), 0);
  endtask

  task automatic b_drain();
    for (int t = 0; t < 3000 && q_b.size() != 0; t++) @(negedge clk);
    chk("b_drain", q_b.size(), 0);
  endtask

  initial begin
    logic seen;
    rst_a = 1'b1; rst_b = 1'b1;
    a_din_valid = 0; a_din_sop = 0; a_din_eop = 0; a_din_data = '0;
    b_din_valid = 0; b_din_sop = 0; b_din_eop = 0; b_din_data = '0;
    a_req = 0; a_w = '0; a_h = '0; a_i = '0;
    b_req = 0; b_w = '0; b_h = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_valid", a_dout_valid, 0);
    chk("rst_dout_sop", a_dout_sop, 0);
    chk("rst_dout_eop", a_dout_eop, 0);
    chk("rst_dout_data", a_dout_data, 0);
    chk("rst_ctrl_sent", a_ctrl_sent, 0);
    chk("rst_din_ready", a_din_ready, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    // 640x480 progressive: header at N+2, then a 4-beat video packet
    push_a(24'h00000F, 1, 0, 0);
    push_a(24'h080200, 0, 0, 0);
    push_a(24'h010000, 0, 0, 0);
    push_a(24'h00000E, 0, 1, 1);
    a_req_pulse(16'd640, 16'd480, 4'd0);
    chk("a_hdr_n1_valid", a_dout_valid, 0);
    @(posedge clk); #1;
    chk("a_hdr_n2_valid", a_dout_valid, 1);
    chk("a_hdr_n2_data", a_dout_data, 24'h00000F);
    a_pkt(4, 24'h000000);
    a_drain();

    // request in the middle of a 100-beat video packet
    fork
      a_pkt(100, 24'h100000);
      begin
        repeat (30) @(posedge clk);
        #1;
        push_a_ctrl(16'h0780, 16'h0438, 4'h2);
        a_req_pulse(16'h0780, 16'h0438, 4'h2);
      end
    join
    a_drain();

    // random backpressure
    rnd_en = 1'b1;
    push_a_ctrl(16'h0010, 16'h0020, 4'h1);
    a_req_pulse(16'h0010, 16'h0020, 4'h1);
    a_pkt(6, 24'h200000);
    push_a_ctrl(16'hABCD, 16'h1234, 4'h3);
    a_req_pulse(16'hABCD, 16'h1234, 4'h3);
    a_pkt(3, 24'h300000);
    a_drain();
    rnd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // upstream control packet is swallowed by A
    a_send(24'h00000F, 1, 0);
    a_din_valid = 1'b1; a_din_data = 24'h123456; a_din_sop = 0; a_din_eop = 0;
    #1 chk("a_drop_ready_b1", a_din_ready, 1);
    a_send(24'h123456, 0, 0);
    a_din_valid = 1'b1; a_din_data = 24'h654321; a_din_sop = 0; a_din_eop = 1;
    #1 chk("a_drop_ready_b2", a_din_ready, 1);
    a_send(24'h654321, 0, 1);
    @(negedge clk);
    chk("a_drop_no_output", a_dout_valid, 0);
    a_pkt(2, 24'h400000);
    a_drain();

    // S=1, width 0x1234 height 0x0567 interlaced 8
    push_b_ctrl(bv1);
    b_req_pulse(16'h1234, 16'h0567, 4'h8);
    b_drain();

    // upstream control packet is forwarded verbatim by B
    q_b.push_back('{data: 24'h0F, sop: 1, eop: 0, last: 0});
    q_b.push_back('{data: 24'h05, sop: 0, eop: 0, last: 0});
    q_b.push_back('{data: 24'h06, sop: 0, eop: 1, last: 0});
    b_send(8'h0F, 1, 0);
    b_send(8'h05, 0, 0);
    b_send(8'h06, 0, 1);
    b_drain();

    // reset while the fifth control beat is on the output
    b_ign = 1'b1;
    b_req_pulse(16'h1234, 16'h0567, 4'h8);
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b_dout_valid && b_dout_data == 8'h04) begin seen = 1'b1; break; end
    end
    chk("b_reach_beat5", seen, 1);
    #2 rst_b = 1'b1;
    #1 chk("b_rst_valid", b_dout_valid, 0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    b_ign = 1'b0;
    @(posedge clk); #1;
    push_b_ctrl(bv2);
    b_req_pulse(16'h00AB, 16'h00CD, 4'h1);
    chk("b_after_rst_n1", b_dout_valid, 0);
    @(posedge clk); #1;
    chk("b_after_rst_n2_valid", b_dout_valid, 1);
    chk("b_after_rst_n2_data", b_dout_data, 8'h0F);
    b_drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
